// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(15,11) corrector and its arbiter front end.
// Bit 14 of a codeword is position 1, bit 0 is position 15. The parity bits sit
// at positions 1, 2, 4 and 8, which are bits 14, 13, 11 and 7.
package hamming_pkg;

    localparam int HAM_N = 15;
    localparam int HAM_K = 11;
    localparam int SYN_W = 4;
    localparam int PARITY_POS [SYN_W] = '{14, 13, 11, 7};

    // Output register occupancy: LIVRE = empty, CHEIO = result held
    typedef enum logic {
        LIVRE = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    // Each syndrome bit covers the positions (15 - bit index) with that bit set
    function automatic logic [SYN_W-1:0] sindrome(input logic [HAM_N-1:0] w);
        logic [SYN_W-1:0] s;
        s[0] = ^{w[14], w[12], w[10], w[8], w[6], w[4], w[2], w[0]};
        s[1] = ^{w[13], w[12], w[9],  w[8], w[5], w[4], w[1], w[0]};
        s[2] = ^{w[11], w[10], w[9],  w[8], w[3], w[2], w[1], w[0]};
        s[3] = ^{w[7],  w[6],  w[5],  w[4], w[3], w[2], w[1], w[0]};
        return s;
    endfunction

    // Drop the parity bits, keep the data bits in descending order
    function automatic logic [HAM_K-1:0] extrai_dados(input logic [HAM_N-1:0] c);
        return {c[12], c[10], c[9], c[8], c[6], c[5], c[4], c[3], c[2], c[1], c[0]};
    endfunction

endpackage

// File: rtl/arbitro_hamming_sindrome.sv
// sindrome_hamming: purely combinational single-error corrector.
// Computes the syndrome of the received word, flips the addressed bit
// (syndrome s selects bit 15-s) and returns the 11 data bits.
module sindrome_hamming
    import hamming_pkg::*;
(
    input  logic [HAM_N-1:0] i_word,
    output logic [SYN_W-1:0] o_syn,
    output logic [HAM_K-1:0] o_data
);

    logic [SYN_W-1:0] w_syn;
    logic [HAM_N-1:0] w_flip;
    logic [HAM_N-1:0] w_corr;

    assign w_syn = sindrome(i_word);

    // One decoder line per bit; syndrome 0 matches nothing, so clean words pass through
    generate
        for (genvar gi = 0; gi < HAM_N; gi++) begin : g_flip
            assign w_flip[gi] = (w_syn == SYN_W'(HAM_N - gi));
        end
    endgenerate

    assign w_corr = i_word ^ w_flip;
    assign o_syn  = w_syn;
    assign o_data = extrai_dados(w_corr);

endmodule

// File: rtl/arbitro_hamming.sv
// arbitro_hamming: round-robin share of one Hamming(15,11) corrector among
// N_REQ requesters, with a single output register and ready/valid handshakes.
// Optional feature: define ARBITRO_CONTADOR_ERRO_EN to build the saturating
// error counter; otherwise err_count is tied to zero.
module arbitro_hamming
    import hamming_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [HAM_N*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HAM_K-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    output logic [SYN_W-1:0]         out_syn,
    output logic [CNT_W-1:0]         err_count
);

    estado_t          r_estado;
    estado_t          w_estado_next;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_next;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_any_valid;
    logic             w_pode;
    logic             w_gnt;
    int               v_idx;
    logic [HAM_K-1:0] r_data;
    logic [ID_W-1:0]  r_id;
    logic [SYN_W-1:0] r_syn;
    logic [SYN_W-1:0] w_syn;
    logic [HAM_K-1:0] w_data;
    logic [HAM_N-1:0] w_words [N_REQ];

    // Split the flat request bus into one codeword per requester
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
            assign w_words[gi] = req_data[HAM_N*gi +: HAM_N];
        end
    endgenerate

    // Round-robin scan: first valid requester at or after the pointer, with wrap
    always_comb begin
        w_any_valid = 1'b0;
        w_gnt_idx   = '0;
        v_idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_any_valid && req_valid[v_idx]) begin
                w_any_valid = 1'b1;
                w_gnt_idx   = ID_W'(v_idx);
            end
        end
    end

    // A grant needs a free register, or one being drained this cycle; never during reset
    assign w_pode = !rst && ((r_estado == LIVRE) || out_ready);
    assign w_gnt  = w_pode && w_any_valid;

    // One-hot ready towards the granted requester only
    always_comb begin
        req_ready = '0;
        if (w_gnt) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner; holds when nothing is accepted
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_gnt) begin
            w_ptr_next = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    sindrome_hamming u_sindrome (
        .i_word (w_words[w_gnt_idx]),
        .o_syn  (w_syn),
        .o_data (w_data)
    );

    // Output occupancy: fill on grant, empty on drain without refill
    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            LIVRE:   if (w_gnt) w_estado_next = CHEIO;
            CHEIO:   if (out_ready && !w_gnt) w_estado_next = LIVRE;
            default: w_estado_next = LIVRE;
        endcase
    end

    // State and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= LIVRE;
            r_ptr    <= '0;
        end else begin
            r_estado <= w_estado_next;
            r_ptr    <= w_ptr_next;
        end
    end

    // Result register loads only on a grant, so it is stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_id   <= '0;
            r_syn  <= '0;
        end else if (w_gnt) begin
            r_data <= w_data;
            r_id   <= w_gnt_idx;
            r_syn  <= w_syn;
        end
    end

    assign out_valid = (r_estado == CHEIO);
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign out_syn   = r_syn;

`ifdef ARBITRO_CONTADOR_ERRO_EN
    logic [CNT_W-1:0] r_err_cnt;

    // Count delivered results with a non-zero syndrome, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (out_valid && out_ready && (r_syn != '0) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_arbitro_hamming.sv
// Directed testbench for arbitro_hamming (N_REQ=4, CNT_W=2).
// Expected values are hand-computed Hamming(15,11) results.
module tb_arbitro_hamming;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [15*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [10:0]          out_data;
    logic [ID_W-1:0]      out_id;
    logic [3:0]           out_syn;
    logic [CNT_W-1:0]     err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    arbitro_hamming #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_syn   (out_syn),
        .err_count (err_count)
    );

    task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single requester sends a word; check ready now and the result next cycle
    task automatic send_one(input int idx, input logic [14:0] word,
                            input logic [3:0] e_syn, input logic [10:0] e_data);
        req_valid            = '0;
        req_valid[idx]       = 1'b1;
        req_data[15*idx +: 15] = word;
        out_ready            = 1'b1;
        #1;
        verifica($sformatf("ready_req%0d", idx), 32'(req_ready), 32'(1 << idx));
        step();
        req_valid = '0;
        verifica($sformatf("valid_w%0h", word), 32'(out_valid), 32'd1);
        verifica($sformatf("syn_w%0h", word), 32'(out_syn), 32'(e_syn));
        verifica($sformatf("data_w%0h", word), 32'(out_data), 32'(e_data));
        verifica($sformatf("id_w%0h", word), 32'(out_id), 32'(idx));
        $display("[TB] req%0d word=%04h -> syn=%0h data=%03h id=%0d",
                 idx, word, out_syn, out_data, out_id);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        verifica("rst_out_valid", 32'(out_valid), 32'd0);
        verifica("rst_out_data",  32'(out_data),  32'd0);
        verifica("rst_out_id",    32'(out_id),    32'd0);
        verifica("rst_out_syn",   32'(out_syn),   32'd0);
        verifica("rst_err_count", 32'(err_count), 32'd0);
        verifica("rst_req_ready", 32'(req_ready), 32'd0);

        // Single-word vectors, including a double error that miscorrects
        send_one(0, 15'h0000, 4'h0, 11'h000);
        send_one(1, 15'h0008, 4'hC, 11'h000);
        send_one(2, 15'h7FFE, 4'hF, 11'h7FF);
        send_one(3, 15'h4000, 4'h1, 11'h000);
        send_one(0, 15'h7000, 4'h0, 11'h400);
        send_one(1, 15'h7001, 4'hF, 11'h400);
        send_one(2, 15'h0003, 4'h1, 11'h003);
        send_one(3, 15'h6FFF, 4'h3, 11'h7FF);

        // Drain with nothing pending
        step();
        verifica("drain_empty", 32'(out_valid), 32'd0);

        // All requesters valid, pointer at 0: grants rotate every cycle
        req_data  = {15'h4000, 15'h7FFE, 15'h0008, 15'h7001};
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            verifica($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            step();
            verifica($sformatf("rr_id_%0d", k), 32'(out_id), 32'(k % 4));
            verifica($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
            $display("[TB] rr cycle %0d out_id=%0d", k, out_id);
        end

        // Stall: result from req0 (0x7001) is held, no grant
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            verifica($sformatf("stall_ready_%0d", k), 32'(req_ready), 32'd0);
            verifica($sformatf("stall_data_%0d", k), 32'(out_data), 32'h400);
            verifica($sformatf("stall_syn_%0d", k), 32'(out_syn), 32'hF);
            verifica($sformatf("stall_id_%0d", k), 32'(out_id), 32'd0);
            step();
            $display("[TB] stall cycle %0d out_id=%0d data=%03h", k, out_id, out_data);
        end
        out_ready = 1'b1;
        #1;
        verifica("release_ready", 32'(req_ready), 32'h2);
        step();
        verifica("release_id",  32'(out_id),  32'd1);
        verifica("release_syn", 32'(out_syn), 32'hC);

        // Reset while a result is held; pointer must return to 0
        rst = 1'b1;
        #1;
        verifica("rst_no_grant", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        verifica("rst_mid_valid", 32'(out_valid), 32'd0);
        verifica("rst_mid_count", 32'(err_count), 32'd0);
        #1;
        verifica("rst_first_grant", 32'(req_ready), 32'h1);
        step();
        verifica("rst_first_id", 32'(out_id), 32'd0);
        $display("[TB] after reset first grant out_id=%0d", out_id);

        // Error counter: clean start, then five error words drained one by one
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            req_valid    = 4'h1;
            req_data[14:0] = 15'h0008;
            out_ready    = 1'b1;
            step();
            req_valid = '0;
            step();
`ifdef ARBITRO_CONTADOR_ERRO_EN
            if (exp_cnt < 3) exp_cnt++;
`endif
            verifica($sformatf("err_count_%0d", k), 32'(err_count), 32'(exp_cnt));
            $display("[TB] error word %0d drained err_count=%0d", k, err_count);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
